// File: rtl/note_pkg.sv
// Shared types and constants for the arpeggio note sequencer.
package note_pkg;

  localparam int NUM_NOTES = 8;
  localparam int NOTE_W    = 6;
  localparam int NOTES_W   = NUM_NOTES * NOTE_W;
  localparam int IDX_W     = $clog2(NUM_NOTES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SOUND = 2'd1,
    GAP   = 2'd2
  } seq_state_t;

  // Extract slot idx from the packed notes bus (slot i = notes[6i+5:6i]).
  function automatic logic [NOTE_W-1:0] slot_note(input logic [NOTES_W-1:0] notes,
                                                  input logic [IDX_W-1:0]   idx);
    return notes[int'(idx)*NOTE_W +: NOTE_W];
  endfunction

endpackage

// File: rtl/next_slot_finder.sv
// Combinational search for the next enabled slot: either the lowest set bit of
// the mask (i_first=1) or the lowest set bit strictly above i_cur.
module next_slot_finder
  import note_pkg::*;
(
  input  logic [NUM_NOTES-1:0] i_mask,
  input  logic [IDX_W-1:0]     i_cur,
  input  logic                 i_first,
  output logic [IDX_W-1:0]     o_idx,
  output logic                 o_found
);

  // Scan from the top down so the lowest qualifying bit is the last one written.
  always_comb begin
    // NOTE: every output gets a default before any conditional write, otherwise
    // paths that skip the assignment would infer a latch.
    o_idx   = '0;
    o_found = 1'b0;
    for (int i = NUM_NOTES - 1; i >= 0; i--) begin
      if (i_mask[i] && (i_first || (i > int'(i_cur)))) begin
        o_idx   = IDX_W'(i);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// Arpeggiator: snapshots the chord and enable mask, then sounds each enabled
// slot in ascending order for STEP_CYCLES with a GAP_CYCLES silence after it.
// Outputs are registered; gate/note follow the SOUND state by one cycle, while
// busy and done track the state register exactly.
module note_sequencer
  import note_pkg::*;
#(
  parameter int STEP_CYCLES = 12_500_000,
  parameter int GAP_CYCLES  = 1_250_000
)
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NOTES_W-1:0]   notes,
  input  logic [NUM_NOTES-1:0] enable,
  input  logic                 play,
  input  logic                 loop,
  output logic [NOTE_W-1:0]    note_out,
  output logic                 gate,
  output logic [IDX_W-1:0]     step_idx,
  output logic                 busy,
  output logic                 done
);

  localparam int MAX_CYCLES = (STEP_CYCLES > GAP_CYCLES) ? STEP_CYCLES : GAP_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  seq_state_t           r_state, w_next_state;
  logic [CNT_W-1:0]     r_cnt, w_cnt_next;
  logic [IDX_W-1:0]     r_idx, w_idx_next;
  logic [NOTES_W-1:0]   r_notes;
  logic [NUM_NOTES-1:0] r_en;
  logic                 w_load;
  logic                 w_done_next;
  logic                 w_abort;
  logic                 w_sound_out;

  logic [IDX_W-1:0]     w_adv_idx, w_first_idx;
  logic                 w_adv_found, w_first_found;

  logic [NOTE_W-1:0]    r_note_out;
  logic                 r_gate;
  logic [IDX_W-1:0]     r_step_idx;
  logic                 r_busy;
  logic                 r_done;

  // Next enabled slot above the current one within the snapshot.
  next_slot_finder u_adv (
    .i_mask  (r_en),
    .i_cur   (r_idx),
    .i_first (1'b0),
    .o_idx   (w_adv_idx),
    .o_found (w_adv_found)
  );

  // Lowest enabled slot of the live mask, used when a pattern (re)starts.
  next_slot_finder u_first (
    .i_mask  (enable),
    .i_cur   ('0),
    .i_first (1'b1),
    .o_idx   (w_first_idx),
    .o_found (w_first_found)
  );

  assign w_abort     = (r_state != IDLE) && !play;
  assign w_sound_out = (r_state == SOUND) && !w_abort;

  // Next-state, step counter, slot index and snapshot-load decisions.
  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    w_idx_next   = r_idx;
    w_load       = 1'b0;
    w_done_next  = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_cnt_next = '0;
        if (play && w_first_found) begin
          w_load       = 1'b1;
          w_idx_next   = w_first_idx;
          w_next_state = SOUND;
        end
      end
      SOUND: begin
        if (w_abort) begin
          w_cnt_next   = '0;
          w_next_state = IDLE;
        end else if (r_cnt == STEP_LAST) begin
          w_cnt_next   = '0;
          w_next_state = GAP;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      GAP: begin
        if (w_abort) begin
          w_cnt_next   = '0;
          w_next_state = IDLE;
        end else if (r_cnt == GAP_LAST) begin
          w_cnt_next = '0;
          if (w_adv_found) begin
            w_idx_next   = w_adv_idx;
            w_next_state = SOUND;
          end else if (loop) begin
            // Wrap straight into the new pattern so the step period is unchanged.
            if (w_first_found) begin
              w_load       = 1'b1;
              w_idx_next   = w_first_idx;
              w_next_state = SOUND;
            end else begin
              w_next_state = IDLE;
            end
          end else begin
            w_done_next  = 1'b1;
            w_next_state = IDLE;
          end
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: begin
        w_cnt_next   = '0;
        w_next_state = IDLE;
      end
    endcase
  end

  // State register with step counter and current slot index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      r_state <= w_next_state;
      r_cnt   <= w_cnt_next;
      r_idx   <= w_idx_next;
    end
  end

  // Chord and mask snapshot; later changes on the live inputs are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the snapshot is cleared on reset because it is only a few flops
      // and a known value keeps note_out deterministic after any restart.
      r_notes <= '0;
      r_en    <= '0;
    end else if (w_load) begin
      r_notes <= notes;
      r_en    <= enable;
    end
  end

  // Registered outputs; note and index are held outside SOUND.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_note_out <= '0;
      r_gate     <= 1'b0;
      r_step_idx <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_gate <= w_sound_out;
      if (w_sound_out) begin
        r_note_out <= slot_note(r_notes, r_idx);
        r_step_idx <= r_idx;
      end
      r_busy <= (w_next_state != IDLE);
      r_done <= w_done_next;
    end
  end

  assign note_out = r_note_out;
  assign gate     = r_gate;
  assign step_idx = r_step_idx;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule

// File: doc/note_sequencer.md
# note_sequencer

Steps through the 8-slot chord produced by `switch_to_note` and plays its enabled notes one at a time as an arpeggio. It consumes the 48-bit `notes` bus plus the same 8-bit switch vector as an enable mask. It drives a single 6-bit note and a gate to the downstream tone generator. Note and step timing come from per-step cycle counters; the pattern can run once or loop.

## Interface
- `NUM_NOTES`, 8, slots in the `notes` bus
- `NOTE_W`, 6, bits per note
- `STEP_CYCLES`, 12_500_000, cycles the gate is high per step (≥1)
- `GAP_CYCLES`, 1_250_000, cycles the gate is low after each step (≥1)

- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous, active-low reset
- `notes`  in  48  slot i = `notes[6i+5:6i]`, from `switch_to_note`
- `enable`  in  8  slot enable mask (the switch vector); bit i enables slot i
- `play`  in  1  level; high = run, low = stop
- `loop`  in  1  level; sampled at pattern end
- `note_out`  out  6  current note to the tone generator
- `gate`  out  1  tone on
- `step_idx`  out  3  slot currently sounding
- `busy`  out  1  high in any state other than IDLE
- `done`  out  1  one-cycle pulse when a non-looping pattern completes

## Operation
- States: IDLE, SOUND, GAP.
- IDLE:
  - If `play`=1 and `enable`≠0: snapshot `notes` and `enable` into internal registers.
  - Set `step_idx` to the lowest set bit of `enable` and enter SOUND.
  - `enable`=0 with `play`=1: stay in IDLE, outputs unchanged.
- SOUND:
  - `gate`=1 and `note_out` = snapshot slot `step_idx`.
  - Count `STEP_CYCLES`, then go to GAP.
- GAP:
  - `gate`=0, `note_out` held.
  - Count `GAP_CYCLES`, then advance to the next set bit of the snapshot mask strictly above `step_idx`, and enter SOUND.
- No higher bit (pattern end):
  - `loop`=1: re-snapshot live `notes`/`enable`. If the new mask ≠0, go to SOUND at its lowest set bit. If the new mask =0, go to IDLE without a `done` pulse.
  - `loop`=0: pulse `done` for one cycle and go to IDLE.
- Live `notes`/`enable` changes mid-pattern are ignored until the next snapshot.
- `play` falling in SOUND or GAP aborts the pattern:
  - Next cycle: IDLE, `gate`=0, counter cleared, no `done`.
- A single enabled slot plays repeatedly while looping; with `loop`=0 it plays once and then pulses `done`.
- Note value 0 is legal and played like any other; the gate is controlled only by state.

## Timing
- Reset values: `note_out`=0, `gate`=0, `step_idx`=0, `busy`=0, `done`=0, state IDLE, counter 0, snapshot 0.
- Start latency: a `play`=1 sample at edge N gives `gate`=1 and a valid `note_out` after edge N+1.
- `gate` is high for exactly `STEP_CYCLES` cycles, then low for exactly `GAP_CYCLES` cycles.
- Step period is `STEP_CYCLES`+`GAP_CYCLES`, with no extra cycle at a loop wrap.
- `done` is asserted in the cycle the state returns to IDLE.
- If `play` stays high, the next pattern starts on the following edge (one IDLE cycle).
- Counter width is `$clog2(max(STEP_CYCLES,GAP_CYCLES))`+1. The counter resets to 0 on every state change and compares with `==` (terminal count − 1).
- All outputs are registered. Asynchronous reset mid-pattern forces reset values immediately.

## Structure
- Package `note_pkg`: `NOTE_W`, `NUM_NOTES`, `NOTES_W`=48, state enum `seq_state_t` {IDLE, SOUND, GAP}.
- Sub-module `next_slot_finder` (combinational): inputs are the mask and current index plus a `first` select. It returns the next set index above current (or the lowest set index) and a `found` flag.

## Test plan
All scenarios use `STEP_CYCLES`=4, `GAP_CYCLES`=2.
- Reset: hold `rst_n`=0 with `play`=1 → all outputs 0. Release → `gate` rises 2 edges later.
- `enable`=10100010, slots 1/5/7 = 2/9/12, `loop`=0, `play`=1:
  - `note_out` sequence 2, 9, 12, each with 4 cycles gate high and 2 low.
  - `step_idx` 1, 5, 7.
  - `done` pulses once; then a new pattern starts.
- `loop`=1, `enable`=10000000, slot 7=23 → 23 repeats every 6 cycles; `done` never pulses.
- Change `notes`/`enable` to 00000001 (slot 0=5) during the second step of a looping 10100010 pattern → remaining steps use the old snapshot; the next wrap plays 5 only.
- Drop `play` during the SOUND of slot 5 → next cycle `gate`=0, `busy`=0, no `done`. Re-raise → restart at slot 1.
- `enable`=00000000 with `play`=1 → stays IDLE, `busy`=0. `enable`=11111111 → all 8 slots in order 0..7, 48 cycles per pattern.
